// File: rtl/dataflow_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dataflow_deadlock_monitor
// Description : N-process dataflow deadlock monitor with persistence filter,
//               sticky flag, blocked-process snapshot and saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dataflow_deadlock_monitor #(
    parameter int NUM_PROC    = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_PROC-1:0] axis_block_sigs,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                deadlock,
    output logic [NUM_PROC-1:0] deadlock_vec,
    output logic [CNT_W-1:0]    event_count
);

    localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LATCHED = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] cnt;
    logic              cond;
    logic              latch_now;

    // A process counts as stopped if it is idle or stalled on any channel.
    assign cond = (|axis_block_sigs) &
                  (&(inst_idle_sigs | inst_block_sigs | axis_block_sigs));

    assign latch_now = !clear && cond &&
                       (((state == S_IDLE) && (HOLD_CYCLES == 1)) ||
                        ((state == S_ARMED) && (cnt == HOLD_LAST)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            block        <= 1'b0;
            deadlock     <= 1'b0;
            deadlock_vec <= '0;
            event_count  <= '0;
        end else begin
            block <= cond;

            case (state)
                S_IDLE: begin
                    if (latch_now) begin
                        state <= S_LATCHED;
                        cnt   <= '0;
                    end else if (!clear && cond) begin
                        state <= S_ARMED;
                        cnt   <= HOLD_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_ARMED: begin
                    if (clear || !cond) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (latch_now) begin
                        state <= S_LATCHED;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + HOLD_W'(1);
                    end
                end
                S_LATCHED: begin
                    if (clear) begin
                        state        <= S_IDLE;
                        cnt          <= '0;
                        deadlock     <= 1'b0;
                        deadlock_vec <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase

            if (latch_now) begin
                deadlock     <= 1'b1;
                deadlock_vec <= axis_block_sigs | inst_block_sigs;
                if (event_count != CNT_MAX) begin
                    event_count <= event_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dataflow_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_dataflow_deadlock_monitor
// Description : Bench for two monitor configurations (HOLD 4 / HOLD 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dataflow_deadlock_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] axis, idle, chan;
    logic       clr;

    logic       blk1, dl1, blk2, dl2;
    logic [2:0] vec1, vec2;
    logic [3:0] ec1;
    logic [1:0] ec2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dataflow_deadlock_monitor #(.NUM_PROC(3), .HOLD_CYCLES(4), .CNT_W(4)) u_dut1 (
        .clock(clk), .reset(rst), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(chan), .clear(clr), .block(blk1), .deadlock(dl1),
        .deadlock_vec(vec1), .event_count(ec1)
    );

    dataflow_deadlock_monitor #(.NUM_PROC(3), .HOLD_CYCLES(1), .CNT_W(2)) u_dut2 (
        .clock(clk), .reset(rst), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(chan), .clear(clr), .block(blk2), .deadlock(dl2),
        .deadlock_vec(vec2), .event_count(ec2)
    );

    // Reference: consecutive-run counting with a sticky latch per configuration.
    int   hold_c [2] = '{4, 1};
    int   max_c  [2] = '{15, 3};
    bit   m_blk  [2];
    bit   m_dl   [2];
    int   m_vec  [2];
    int   m_ec   [2];
    int   m_run  [2];
    bit   started = 1'b0;

    always @(posedge clk) begin
        bit c;
        c = (axis != 3'b000) && ((axis | idle | chan) == 3'b111);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_blk[k] = 1'b0; m_dl[k] = 1'b0; m_vec[k] = 0; m_ec[k] = 0; m_run[k] = 0;
            end else begin
                m_blk[k] = c;
                if (m_dl[k]) begin
                    if (clr) begin
                        m_dl[k] = 1'b0; m_vec[k] = 0; m_run[k] = 0;
                    end
                end else if (clr) begin
                    m_run[k] = 0;
                end else if (c) begin
                    m_run[k]++;
                    if (m_run[k] >= hold_c[k]) begin
                        m_dl[k]  = 1'b1;
                        m_vec[k] = int'(axis | chan);
                        if (m_ec[k] < max_c[k]) m_ec[k]++;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("blk1", int'(blk1), int'(m_blk[0]));
            check("dl1",  int'(dl1),  int'(m_dl[0]));
            check("vec1", int'(vec1), m_vec[0]);
            check("ec1",  int'(ec1),  m_ec[0]);
            check("blk2", int'(blk2), int'(m_blk[1]));
            check("dl2",  int'(dl2),  int'(m_dl[1]));
            check("vec2", int'(vec2), m_vec[1]);
            check("ec2",  int'(ec2),  m_ec[1]);
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic [2:0] a, input logic [2:0] i, input logic [2:0] c,
                       input logic cl, input logic r);
        axis = a; idle = i; chan = c; clr = cl; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        axis = '0; idle = '0; chan = '0; clr = 1'b0; rst = 1'b1;
        #1;
        repeat (3) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        repeat (20) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        check("lit_reset_dl",  int'(dl1),  0);
        check("lit_reset_ec",  int'(ec1),  0);
        check("lit_reset_vec", int'(vec1), 0);

        // Four qualifying cycles: latch only after the fourth
        repeat (3) cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        check("lit_pre_latch_dl", int'(dl1),  0);
        check("lit_block_on",     int'(blk1), 1);
        cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        check("lit_latch_dl",  int'(dl1),  1);
        check("lit_latch_vec", int'(vec1), 1);
        check("lit_latch_ec",  int'(ec1),  1);

        // Sticky while inputs drop; clear then relatch
        repeat (3) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        check("lit_sticky_dl", int'(dl1), 1);
        cyc(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        check("lit_clear_dl",  int'(dl1),  0);
        check("lit_clear_vec", int'(vec1), 0);
        repeat (4) cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        check("lit_relatch_dl", int'(dl1), 1);
        check("lit_relatch_ec", int'(ec1), 2);

        // Interrupted run never latches
        cyc(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        repeat (3) cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (3) cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        check("lit_interrupt_dl", int'(dl1), 0);

        // Process 0 not stopped, then stopped via idle
        cyc(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        repeat (4) cyc(3'b010, 3'b000, 3'b100, 1'b0, 1'b0);
        check("lit_nostop_blk", int'(blk1), 0);
        check("lit_nostop_dl",  int'(dl1),  0);
        repeat (4) cyc(3'b010, 3'b001, 3'b100, 1'b0, 1'b0);
        check("lit_mixed_dl",  int'(dl1),  1);
        check("lit_mixed_vec", int'(vec1), 6);
        check("lit_mixed_ec",  int'(ec1),  3);
        check("lit_sat_ec2",   int'(ec2),  3);

        // Clear coincident with cond: no latch that cycle, latch next
        cyc(3'b001, 3'b110, 3'b000, 1'b1, 1'b0);
        check("lit_clr_cond_dl2", int'(dl2), 0);
        cyc(3'b001, 3'b110, 3'b000, 1'b0, 1'b0);
        check("lit_next_cond_dl2", int'(dl2), 1);
        check("lit_next_cond_ec2", int'(ec2), 3);

        for (int n = 0; n < 2000; n++) begin
            logic [2:0] a, i, c;
            if ($urandom_range(0, 9) < 7) begin
                a = '0; i = '0; c = '0;
                for (int b = 0; b < 3; b++) begin
                    case ($urandom_range(0, 2))
                        0:       a[b] = 1'b1;
                        1:       i[b] = 1'b1;
                        default: c[b] = 1'b1;
                    endcase
                end
                if ($urandom_range(0, 3) == 0) c = c | 3'($urandom_range(0, 7));
                if (a == 3'b000) a[$urandom_range(0, 2)] = 1'b1;
            end else begin
                a = 3'($urandom_range(0, 7));
                i = 3'($urandom_range(0, 7));
                c = 3'($urandom_range(0, 7));
            end
            cyc(a, i, c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
